// File: rtl/fc_score_accum.sv
// Ten-class fully-connected score accumulator: streams feature beats, accumulates
// feature*weight per class, then presents the scores. Optional bias add: FC_BIAS_EN.
module fc_score_accum #(
    parameter int N_FEAT = 1352,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_feat,
    input  logic [10*DATA_W-1:0]  in_wvec,
    input  logic                  in_last,
    input  logic [159:0]          bias_vec,
    output logic [31:0]           out0,
    output logic [31:0]           out1,
    output logic [31:0]           out2,
    output logic [31:0]           out3,
    output logic [31:0]           out4,
    output logic [31:0]           out5,
    output logic [31:0]           out6,
    output logic [31:0]           out7,
    output logic [31:0]           out8,
    output logic [31:0]           out9,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  len_err
);

    typedef enum logic [1:0] {
        ACCUM,
        FINAL,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0] acc [10];
    logic [15:0] cnt;
    logic [16:0] cnt_inc;
    logic        beat;
    logic        at_limit;
    logic        frame_end;
    logic        handshake;

    logic signed [2*DATA_W-1:0] feat_x;
    logic signed [2*DATA_W-1:0] w_x  [10];
    logic signed [2*DATA_W-1:0] prod [10];
    logic [31:0]                term [10];

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign beat      = in_valid && in_ready && !clr;
    assign cnt_inc   = {1'b0, cnt} + 17'd1;
    assign at_limit  = (cnt_inc == 17'(N_FEAT));
    assign frame_end = beat && (in_last || at_limit);
    assign handshake = (state == DONE) && out_ready;

    // Operands are widened first so the product carries the full signed precision.
    always_comb begin
        feat_x = (2*DATA_W)'($signed(in_feat));
        for (int k = 0; k < 10; k++) begin
            w_x[k]  = (2*DATA_W)'($signed(in_wvec[k*DATA_W +: DATA_W]));
            prod[k] = feat_x * w_x[k];
            term[k] = 32'(prod[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (frame_end) state_nxt = FINAL;
                FINAL:   state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = ACCUM;
                default: state_nxt = ACCUM;
            endcase
        end
    end

    // Abort and result handoff both start a clean frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 10; k++) acc[k] <= '0;
            cnt     <= '0;
            len_err <= 1'b0;
        end else if (clr || handshake) begin
            for (int k = 0; k < 10; k++) acc[k] <= '0;
            cnt     <= '0;
            len_err <= 1'b0;
        end else if (beat) begin
            for (int k = 0; k < 10; k++) acc[k] <= acc[k] + term[k];
            cnt <= cnt_inc[15:0];
            if (frame_end) begin
                len_err <= !(at_limit && in_last);
            end
        end
`ifdef FC_BIAS_EN
        else if (state == FINAL) begin
            for (int k = 0; k < 10; k++) begin
                acc[k] <= acc[k] + 32'($signed(bias_vec[k*16 +: 16]));
            end
        end
`endif
    end

`ifndef FC_BIAS_EN
    logic unused_bias;
    assign unused_bias = ^bias_vec;
`endif

    assign out0 = (state == DONE) ? acc[0] : '0;
    assign out1 = (state == DONE) ? acc[1] : '0;
    assign out2 = (state == DONE) ? acc[2] : '0;
    assign out3 = (state == DONE) ? acc[3] : '0;
    assign out4 = (state == DONE) ? acc[4] : '0;
    assign out5 = (state == DONE) ? acc[5] : '0;
    assign out6 = (state == DONE) ? acc[6] : '0;
    assign out7 = (state == DONE) ? acc[7] : '0;
    assign out8 = (state == DONE) ? acc[8] : '0;
    assign out9 = (state == DONE) ? acc[9] : '0;

endmodule

// File: tb/tb_fc_score_accum.sv
// Self-checking bench for fc_score_accum (N_FEAT=4) against a sum-of-products
// reference model; the bias term follows FC_BIAS_EN like the design.
module tb_fc_score_accum;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_feat;
    logic [79:0]  in_wvec;
    logic         in_last;
    logic [159:0] bias_vec;
    logic [31:0]  out0, out1, out2, out3, out4, out5, out6, out7, out8, out9;
    logic         out_valid;
    logic         out_ready;
    logic         len_err;

    logic [31:0]  outs [10];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           f_arr [N];
    int           w_arr [N][10];
    int           exp_out [10];

    fc_score_accum #(.N_FEAT(N), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
        .in_wvec(in_wvec), .in_last(in_last), .bias_vec(bias_vec),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3), .out4(out4),
        .out5(out5), .out6(out6), .out7(out7), .out8(out8), .out9(out9),
        .out_valid(out_valid), .out_ready(out_ready), .len_err(len_err)
    );

    assign outs[0] = out0;
    assign outs[1] = out1;
    assign outs[2] = out2;
    assign outs[3] = out3;
    assign outs[4] = out4;
    assign outs[5] = out5;
    assign outs[6] = out6;
    assign outs[7] = out7;
    assign outs[8] = out8;
    assign outs[9] = out9;

    always #5 clk = ~clk;

    // Score of class k = sum over accepted beats of feat*weight, plus bias when enabled.
    function automatic void model(input int len);
        shortint b;
        for (int k = 0; k < 10; k++) begin
            int s;
            s = 0;
            for (int i = 0; i < len; i++) s += f_arr[i] * w_arr[i][k];
`ifdef FC_BIAS_EN
            b = bias_vec[k*16 +: 16];
            s += int'(b);
`else
            b = 0;
            s += int'(b);
`endif
            exp_out[k] = s;
        end
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic randomize_frame();
        for (int i = 0; i < N; i++) begin
            f_arr[i] = rnd8();
            for (int k = 0; k < 10; k++) w_arr[i][k] = rnd8();
        end
    endtask

    task automatic drive_beat(input int i, input logic last);
        in_feat = 8'(f_arr[i]);
        for (int k = 0; k < 10; k++) in_wvec[k*8 +: 8] = 8'(w_arr[i][k]);
        in_valid = 1'b1;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_feat = '0; in_wvec = '0; bias_vec = '0; out_ready = 1'b0;
        #12;
        n_cmp++;
        if (out_valid !== 1'b0 || len_err !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL reset_ctrl: got ov=%b le=%b rdy=%b expected 0 0 1", out_valid, len_err, in_ready);
        end
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (outs[k] !== 32'd0) begin
                n_bad++;
                $display("[TB] FAIL reset_out%0d: got %0d expected 0", k, outs[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        bias_vec = '0;
        for (int i = 0; i < N; i++) begin
            f_arr[i] = i + 1;
            for (int k = 0; k < 10; k++) w_arr[i][k] = 1;
        end
        model(N);
        for (int i = 0; i < N; i++) drive_beat(i, i == N - 1);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL basic_final_cycle: got ov=%b rdy=%b expected 0 0", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || len_err !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL basic_done: got ov=%b le=%b expected 1 0", out_valid, len_err);
        end
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (outs[k] !== 32'(exp_out[k]) || outs[k] !== 32'd10) begin
                n_bad++;
                $display("[TB] FAIL basic_out%0d: got %0d expected %0d", k, $signed(outs[k]), exp_out[k]);
            end
        end
        release_result();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out0 !== 32'd0) begin
            n_bad++;
            $display("[TB] FAIL basic_handoff: got ov=%b rdy=%b out0=%0d expected 0 1 0", out_valid, in_ready, out0);
        end
    endtask

    task automatic test_extreme();
        int cyc;
        bias_vec = '0;
        for (int i = 0; i < N; i++) begin
            f_arr[i] = -128;
            for (int k = 0; k < 10; k++) w_arr[i][k] = 0;
            w_arr[i][0] = -128;
            w_arr[i][1] = 127;
        end
        model(N);
        for (int i = 0; i < N; i++) drive_beat(i, i == N - 1);
        wait_out_valid(cyc);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL extreme_timeout: got ov=%b expected 1", out_valid);
        end
        n_cmp++;
        if (out0 !== 32'd65536 || $signed(out1) !== -32'sd65024) begin
            n_bad++;
            $display("[TB] FAIL extreme_vals: got %0d %0d expected 65536 -65024", $signed(out0), $signed(out1));
        end
        for (int k = 2; k < 10; k++) begin
            n_cmp++;
            if (outs[k] !== 32'(exp_out[k])) begin
                n_bad++;
                $display("[TB] FAIL extreme_out%0d: got %0d expected %0d", k, $signed(outs[k]), exp_out[k]);
            end
        end
        release_result();
    endtask

    task automatic test_bias();
        int cyc;
        bias_vec = '0;
        bias_vec[3*16 +: 16] = 16'hFFFB;
        randomize_frame();
        for (int i = 0; i < N; i++) f_arr[i] = 0;
        model(N);
        for (int i = 0; i < N; i++) drive_beat(i, i == N - 1);
        wait_out_valid(cyc);
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || outs[k] !== 32'(exp_out[k])) begin
                n_bad++;
                $display("[TB] FAIL bias_out%0d: got %0d ov=%b expected %0d", k, $signed(outs[k]), out_valid, exp_out[k]);
            end
        end
        release_result();
    endtask

    task automatic test_short_frame();
        int cyc;
        bias_vec = {$urandom, $urandom, $urandom, $urandom, $urandom};
        randomize_frame();
        model(2);
        drive_beat(0, 1'b0);
        drive_beat(1, 1'b1);
        wait_out_valid(cyc);
        n_cmp++;
        if (out_valid !== 1'b1 || len_err !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL short_len_err: got ov=%b le=%b expected 1 1", out_valid, len_err);
        end
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_feat = 8'($urandom);
            @(posedge clk);
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || len_err !== 1'b1) begin
                n_bad++;
                $display("[TB] FAIL short_hold_ctrl: got ov=%b rdy=%b le=%b expected 1 0 1", out_valid, in_ready, len_err);
            end
            for (int k = 0; k < 10; k++) begin
                n_cmp++;
                if (outs[k] !== 32'(exp_out[k])) begin
                    n_bad++;
                    $display("[TB] FAIL short_hold_out%0d: got %0d expected %0d", k, $signed(outs[k]), exp_out[k]);
                end
            end
        end
        in_valid = 1'b0;
        release_result();
    endtask

    task automatic test_clr();
        int cyc;
        bias_vec = {$urandom, $urandom, $urandom, $urandom, $urandom};
        randomize_frame();
        drive_beat(0, 1'b0);
        drive_beat(1, 1'b0);
        clr = 1'b1;
        drive_beat(2, 1'b0);
        clr = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL clr_state: got rdy=%b ov=%b expected 1 0", in_ready, out_valid);
        end
        randomize_frame();
        model(N);
        for (int i = 0; i < N; i++) drive_beat(i, i == N - 1);
        wait_out_valid(cyc);
        n_cmp++;
        if (out_valid !== 1'b1 || len_err !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL clr_frame_done: got ov=%b le=%b expected 1 0", out_valid, len_err);
        end
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (outs[k] !== 32'(exp_out[k])) begin
                n_bad++;
                $display("[TB] FAIL clr_out%0d: got %0d expected %0d", k, $signed(outs[k]), exp_out[k]);
            end
        end
        // Abort wins over a simultaneous handoff; the result is dropped either way.
        clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL clr_in_done: got ov=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_in_done();
        int cyc;
        bias_vec = {$urandom, $urandom, $urandom, $urandom, $urandom};
        randomize_frame();
        for (int i = 0; i < N; i++) drive_beat(i, i == N - 1);
        wait_out_valid(cyc);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out0 !== 32'd0 || len_err !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_in_done: got ov=%b out0=%0d le=%b expected 0 0 0", out_valid, out0, len_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        randomize_frame();
        drive_beat(0, 1'b0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        randomize_frame();
        model(N);
        for (int i = 0; i < N; i++) drive_beat(i, i == N - 1);
        wait_out_valid(cyc);
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || outs[k] !== 32'(exp_out[k])) begin
                n_bad++;
                $display("[TB] FAIL reset_mid_out%0d: got %0d ov=%b expected %0d", k, $signed(outs[k]), out_valid, exp_out[k]);
            end
        end
        release_result();
    endtask

    task automatic test_random();
        int   cyc;
        int   len;
        logic last;
        logic exp_err;
        for (int t = 0; t < 25; t++) begin
            bias_vec = {$urandom, $urandom, $urandom, $urandom, $urandom};
            randomize_frame();
            len  = int'($urandom_range(1, N));
            last = (len < N) ? 1'b1 : 1'($urandom);
            exp_err = !(len == N && last);
            model(len);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                drive_beat(i, (i == len - 1) ? last : 1'b0);
            end
            wait_out_valid(cyc);
            n_cmp++;
            if (out_valid !== 1'b1 || len_err !== exp_err) begin
                n_bad++;
                $display("[TB] FAIL rand%0d_ctrl: got ov=%b le=%b expected 1 %b", t, out_valid, len_err, exp_err);
            end
            for (int k = 0; k < 10; k++) begin
                n_cmp++;
                if (outs[k] !== 32'(exp_out[k])) begin
                    n_bad++;
                    $display("[TB] FAIL rand%0d_out%0d: got %0d expected %0d", t, k, $signed(outs[k]), exp_out[k]);
                end
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            release_result();
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL rand%0d_handoff: got rdy=%b ov=%b expected 1 0", t, in_ready, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extreme();
        test_bias();
        test_short_frame();
        test_clr();
        test_reset_in_done();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fc_score_accum.md
FC_SCORE_ACCUM -- requirements
Module: fc_score_accum

Interface
REQ-001 Parameter N_FEAT, default 1352, SHALL be the number of feature beats per frame (range 2..65535).
REQ-002 Parameter DATA_W, default 8, SHALL be the signed width of each feature and each weight.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be an asynchronous, active-low reset.
REQ-005 Port clr, input, 1, SHALL be a synchronous frame abort.
REQ-006 Port in_valid, input, 1, SHALL mark a valid feature beat.
REQ-007 Port in_ready, output, 1, SHALL indicate a beat can be accepted.
REQ-008 Port in_feat, input, DATA_W, SHALL carry the signed feature value.
REQ-009 Port in_wvec, input, 10*DATA_W, SHALL carry signed weights; class k occupies bits [k*DATA_W +: DATA_W].
REQ-010 Port in_last, input, 1, SHALL mark the final beat of a frame.
REQ-011 Port bias_vec, input, 160, SHALL carry 10 signed 16-bit biases, class k at bits [k*16 +: 16].
REQ-012 Ports out0..out9, output, 32 each, signed, SHALL carry the class scores.
REQ-013 Port out_valid, output, 1, SHALL indicate out0..out9 hold a complete frame result.
REQ-014 Port out_ready, input, 1, SHALL indicate the consumer has taken the result.
REQ-015 Port len_err, output, 1, SHALL flag a frame whose length differed from N_FEAT; it is valid while out_valid=1.

Function
REQ-016 States SHALL be ACCUM, FINAL and DONE; in_ready=1 only in ACCUM.
REQ-017 A beat SHALL be accepted on any edge with in_valid=1 and in_ready=1.
REQ-018 On each accepted beat, acc_k SHALL be updated to acc_k + sext32(in_feat*w_k) for every k, and the beat counter SHALL increment.
REQ-019 Each product SHALL be the full 2*DATA_W signed product; accumulation SHALL wrap modulo 2^32.
REQ-020 ACCUM->FINAL SHALL occur on the accepted beat with in_last=1, or on the accepted beat number N_FEAT, whichever comes first.
REQ-021 len_err SHALL be set when the frame-ending beat is not both beat N_FEAT and in_last=1.
REQ-022 FINAL SHALL last one cycle, then go to DONE, with out_valid=1 in the cycle after FINAL (2 cycles after the final accepted edge).
REQ-023 In DONE, out0..out9, out_valid and len_err SHALL hold stable until out_valid and out_ready are both 1 on the same edge.
REQ-024 On that DONE handshake edge, the accumulators, counter and len_err SHALL clear, and the state SHALL return to ACCUM, so in_ready=1 on the next cycle.
REQ-025 out_k SHALL equal acc_k in DONE and 0 otherwise.
REQ-026 clr=1 SHALL, in any state, clear the accumulators, counter, out_valid and len_err and enter ACCUM; no beat is accepted on that edge.
REQ-027 clr SHALL take priority over a simultaneous beat or output handshake.

Reset
REQ-028 While rst_n=0, the state SHALL be ACCUM, all acc_k and the counter SHALL be 0, out0..out9=0, out_valid=0 and len_err=0.
REQ-029 Reset asserted mid-frame or in DONE SHALL discard the partial or pending result with no output.

Configuration
REQ-030 With macro FC_BIAS_EN defined, FINAL SHALL add sext32(bias_k) to acc_k.
REQ-031 Without FC_BIAS_EN, FINAL SHALL leave acc_k unchanged and bias_vec SHALL be ignored.

Verification
REQ-032 N_FEAT=4; feats 1,2,3,4 with all weights=1, in_last on beat 4, no bias -> out_k=10 for all k, len_err=0, out_valid 2 cycles after beat 4.
REQ-033 Feat=-128, w_0=-128, w_1=127 for 4 beats -> out0=65536, out1=-65024.
REQ-034 FC_BIAS_EN, bias_3=-5, feats all 0 -> out3=-5, other outputs 0.
REQ-035 in_last on beat 2 with N_FEAT=4 -> frame ends, len_err=1; holding out_ready=0 for 10 cycles -> outputs stable, in_ready=0.
REQ-036 clr on beat 3 then a fresh 4-beat frame -> result reflects only the new frame; rst_n pulse in DONE -> out_valid=0 immediately.
